// File: rtl/pc_ras_unit_if.sv
// Control/status bundle between the LC-3 controller and the PC/RAS unit.
// The master drives the next-PC controls; the slave returns PC and stack status.
interface pc_ras_unit_if #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             ld_pc;
    logic [1:0]       sel_pc;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] eab_in;
    logic             push;
    logic             err_clr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ras_top;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output ld_pc, sel_pc, bus_in, eab_in, push, err_clr,
        input  pc, ras_top, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  ld_pc, sel_pc, bus_in, eab_in, push, err_clr,
        output pc, ras_top, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras_unit.sv
// LC-3 program counter with a circular return-address stack; sel_pc==3 pops
// (or swaps with) the stack top, push records PC+1 as the return address.
module pc_ras_unit #(
    parameter int               WIDTH     = 16,
    parameter int               RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = 16'h3000
) (
    input  logic         clk,
    input  logic         reset,
    pc_ras_unit_if.slave pif
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [RAS_DEPTH];
    logic [WIDTH-1:0] pc_r;
    logic [PW-1:0]    sp_r;
    logic [CW-1:0]    cnt_r;
    logic             ovf_r;
    logic             unf_r;

    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] top_s;
    logic [PW-1:0]    top_idx_s;
    logic             empty_s;
    logic             full_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [PW-1:0]    sp_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic             wr_en_s;
    logic [PW-1:0]    wr_idx_s;
    logic             ovf_set_s;
    logic             unf_set_s;

    // sp_r is the next free slot; the top lives one below it, circularly.
    assign pc_inc_s  = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
    assign top_idx_s = sp_r - {{(PW-1){1'b0}}, 1'b1};
    assign empty_s   = (cnt_r == {CW{1'b0}});
    assign full_s    = (cnt_r == CW'(RAS_DEPTH));
    assign top_s     = empty_s ? {WIDTH{1'b0}} : mem_r[top_idx_s];

    // Next-state decode for PC, stack pointer, count and error events.
    always_comb begin
        pc_nxt_s  = pc_r;
        sp_nxt_s  = sp_r;
        cnt_nxt_s = cnt_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = sp_r;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (pif.ld_pc) begin
            if (pif.sel_pc == 2'd3) begin
                if (empty_s) begin
                    unf_set_s = 1'b1;
                end else if (pif.push) begin
                    pc_nxt_s = top_s;
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end else begin
                    pc_nxt_s  = top_s;
                    sp_nxt_s  = top_idx_s;
                    cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                case (pif.sel_pc)
                    2'd0:    pc_nxt_s = pc_inc_s;
                    2'd1:    pc_nxt_s = pif.eab_in;
                    2'd2:    pc_nxt_s = pif.bus_in;
                    default: pc_nxt_s = pc_r;
                endcase
                if (pif.push) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = sp_r;
                    sp_nxt_s = sp_r + {{(PW-1){1'b0}}, 1'b1};
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural state; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r  <= RESET_VEC;
            sp_r  <= {PW{1'b0}};
            cnt_r <= {CW{1'b0}};
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            sp_r  <= sp_nxt_s;
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_set_s | (ovf_r & ~pif.err_clr);
            unf_r <= unf_set_s | (unf_r & ~pif.err_clr);
        end
    end

    // Stack storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s) begin
            mem_r[wr_idx_s] <= pc_inc_s;
        end
    end

    assign pif.pc        = pc_r;
    assign pif.ras_top   = top_s;
    assign pif.ras_count = cnt_r;
    assign pif.ras_empty = empty_s;
    assign pif.ras_full  = full_s;
    assign pif.ras_ovf   = ovf_r;
    assign pif.ras_unf   = unf_r;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: a queue-based stack model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pc_ras_unit;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    bit   model_valid = 1'b0;

    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    bit          m_ovf;
    bit          m_unf;

    pc_ras_unit_if #(.WIDTH(16), .RAS_DEPTH(DEPTH)) pif ();

    pc_ras_unit #(.WIDTH(16), .RAS_DEPTH(DEPTH), .RESET_VEC(16'h3000)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("pc", pif.pc, m_pc);
            chk("ras_top", pif.ras_top, (m_q.size() == 0) ? 16'h0000 : m_q[m_q.size()-1]);
            chk("ras_count", 16'(pif.ras_count), 16'(m_q.size()));
            chk("ras_empty", 16'(pif.ras_empty), 16'(m_q.size() == 0));
            chk("ras_full", 16'(pif.ras_full), 16'(m_q.size() == DEPTH));
            chk("ras_ovf", 16'(pif.ras_ovf), 16'(m_ovf));
            chk("ras_unf", 16'(pif.ras_unf), 16'(m_unf));
        end
    end

    // Drive one cycle, compute the model's next state, commit it at the edge.
    task automatic cyc(input bit rst, input bit ld, input logic [1:0] sel,
                       input logic [15:0] bus, input logic [15:0] eab,
                       input bit psh, input bit clr);
        logic [15:0] n_pc;
        logic [15:0] nq[$];
        logic [15:0] t;
        bit set_o;
        bit set_u;
        reset = rst; pif.ld_pc = ld; pif.sel_pc = sel; pif.bus_in = bus;
        pif.eab_in = eab; pif.push = psh; pif.err_clr = clr;
        n_pc = m_pc; nq = m_q; set_o = 1'b0; set_u = 1'b0;
        if (ld && sel != 2'd3) begin
            n_pc = (sel == 2'd0) ? m_pc + 16'd1 : (sel == 2'd1) ? eab : bus;
            if (psh) begin
                nq.push_back(m_pc + 16'd1);
                if (nq.size() > DEPTH) begin
                    void'(nq.pop_front());
                    set_o = 1'b1;
                end
            end
        end else if (ld) begin
            if (nq.size() == 0) set_u = 1'b1;
            else if (psh) begin
                t = nq[nq.size()-1];
                nq[nq.size()-1] = m_pc + 16'd1;
                n_pc = t;
            end else n_pc = nq.pop_back();
        end
        @(posedge clk);
        if (rst) begin
            m_pc = 16'h3000; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_pc = n_pc; m_q = nq;
            m_ovf = set_o | (m_ovf & !clr);
            m_unf = set_u | (m_unf & !clr);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        pif.ld_pc = 1'b0; pif.sel_pc = 2'd0; pif.bus_in = 16'h0; pif.eab_in = 16'h0;
        pif.push = 1'b0; pif.err_clr = 1'b0;
        @(negedge clk);

        // Reset with a competing load
        repeat (2) cyc(1, 1, 2'd2, 16'h1234, 16'h0, 0, 0);
        chk("rst_pc", pif.pc, 16'h3000);
        chk("rst_count", 16'(pif.ras_count), 16'h0000);
        chk("rst_empty", 16'(pif.ras_empty), 16'h0001);
        chk("rst_flags", 16'({pif.ras_ovf, pif.ras_unf}), 16'h0000);

        // PC+1 wraps; ld_pc=0 holds (push ignored too)
        cyc(0, 1, 2'd2, 16'hFFFF, 16'h0, 0, 0);
        chk("wrap_load", pif.pc, 16'hFFFF);
        cyc(0, 1, 2'd0, 16'h0, 16'h0, 0, 0);
        chk("wrap_inc", pif.pc, 16'h0000);
        repeat (3) cyc(0, 0, 2'd1, 16'h0, 16'h7777, 1, 0);
        chk("hold_pc", pif.pc, 16'h0000);
        chk("hold_count", 16'(pif.ras_count), 16'h0000);

        // Call / return
        cyc(1, 0, 2'd0, 16'h0, 16'h0, 0, 0);
        cyc(0, 1, 2'd1, 16'h0, 16'h4000, 1, 0);
        chk("call_pc", pif.pc, 16'h4000);
        chk("call_top", pif.ras_top, 16'h3001);
        chk("call_count", 16'(pif.ras_count), 16'h0001);
        cyc(0, 1, 2'd3, 16'h0, 16'h0, 0, 0);
        chk("ret_pc", pif.pc, 16'h3001);
        chk("ret_empty", 16'(pif.ras_empty), 16'h0001);

        // Overflow then underflow
        cyc(0, 1, 2'd2, 16'h0010, 16'h0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 2'd2, 16'h0011 + 16'(i), 16'h0, 1, 0);
        chk("ovf_count", 16'(pif.ras_count), 16'h0008);
        chk("ovf_full", 16'(pif.ras_full), 16'h0001);
        chk("ovf_flag", 16'(pif.ras_ovf), 16'h0001);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 2'd3, 16'h0, 16'h0, 0, 0);
            chk("ovf_ret", pif.pc, 16'h0019 - 16'(i));
        end
        cyc(0, 1, 2'd3, 16'h0, 16'h0, 0, 0);
        chk("unf_pc", pif.pc, 16'h0012);
        chk("unf_flag", 16'(pif.ras_unf), 16'h0001);
        cyc(0, 0, 2'd0, 16'h0, 16'h0, 0, 1);
        chk("clr_flags", 16'({pif.ras_ovf, pif.ras_unf}), 16'h0000);

        // Swap
        cyc(1, 0, 2'd0, 16'h0, 16'h0, 0, 0);
        cyc(0, 1, 2'd2, 16'h4FFF, 16'h0, 0, 0);
        cyc(0, 1, 2'd2, 16'h6000, 16'h0, 1, 0);
        chk("swap_pre_top", pif.ras_top, 16'h5000);
        cyc(0, 1, 2'd3, 16'h0, 16'h0, 1, 0);
        chk("swap_pc", pif.pc, 16'h5000);
        chk("swap_top", pif.ras_top, 16'h6001);
        chk("swap_count", 16'(pif.ras_count), 16'h0001);

        // Error beats err_clr; empty swap is an underflow; reset mid-call
        cyc(0, 1, 2'd3, 16'h0, 16'h0, 0, 0);
        cyc(0, 1, 2'd3, 16'h0, 16'h0, 0, 1);
        chk("prio_unf", 16'(pif.ras_unf), 16'h0001);
        cyc(0, 1, 2'd3, 16'h0, 16'h0, 1, 0);
        chk("swap_empty_pc", pif.pc, 16'h6001);
        chk("swap_empty_count", 16'(pif.ras_count), 16'h0000);
        cyc(0, 1, 2'd1, 16'h0, 16'h1000, 1, 0);
        cyc(1, 1, 2'd1, 16'h0, 16'h2000, 1, 0);
        chk("midrst_pc", pif.pc, 16'h3000);
        chk("midrst_count", 16'(pif.ras_count), 16'h0000);
        chk("midrst_unf", 16'(pif.ras_unf), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
